// File: rtl/regfile_pkg.sv
// Shared register-file types and sizing helpers for decode, register and writeback stages.
package regfile_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Source of a read port's registered result
  typedef enum logic [1:0] {
    SEL_MEM  = 2'd0,
    SEL_ZERO = 2'd1,
    SEL_BYP  = 2'd2
  } rd_sel_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// Plain storage array: one synchronous write port, two registered read ports with a shared hold enable.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_a_addr,
  input  logic [ADDR_W-1:0] i_rd_b_addr,
  output logic [WIDTH-1:0]  o_rd_a_data,
  output logic [WIDTH-1:0]  o_rd_b_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_a;
  logic [WIDTH-1:0] r_rd_b;

  // No reset on the array or read registers so the storage maps onto RAM primitives
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) begin
      r_rd_a <= r_mem[i_rd_a_addr];
      r_rd_b <= r_mem[i_rd_b_addr];
    end
  end

  assign o_rd_a_data = r_rd_a;
  assign o_rd_b_data = r_rd_b;

endmodule

// File: rtl/multiport_regfile.sv
// CPU register file: 1 write / 2 read ports, optional hardwired zero and write bypass,
// with a post-reset sweep that zeroes every entry through the write port.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int   WIDTH    = REG_WIDTH,
  parameter int   DEPTH    = REG_DEPTH,
  parameter bit   ZERO_REG = 1'b1,
  parameter bit   BYPASS   = 1'b1,
  localparam int  ADDR_W   = addr_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [WIDTH-1:0]  rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [WIDTH-1:0]  rd_b_data,
  output logic              busy
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [WIDTH-1:0]  r_byp_data;
  logic              w_busy;
  logic              w_bank_wr_en;
  logic [ADDR_W-1:0] w_bank_wr_addr;
  logic [WIDTH-1:0]  w_bank_wr_data;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [WIDTH-1:0]  w_bank_q  [2];
  logic [WIDTH-1:0]  w_rd_data [2];

  assign w_busy = (r_state == CLEAR);
  assign busy   = w_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state   <= READY;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        READY:   r_state <= READY;
        default: begin
          r_state   <= CLEAR;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

  // The clear sweep owns the write port while busy; user writes are dropped then
  always_comb begin
    w_bank_wr_en   = 1'b0;
    w_bank_wr_addr = wr_addr;
    w_bank_wr_data = wr_data;
    if (RST) begin
      w_bank_wr_en = 1'b0;
    end else if (w_busy) begin
      w_bank_wr_en   = 1'b1;
      w_bank_wr_addr = r_clr_cnt;
      w_bank_wr_data = '0;
    end else if (wr_en && !(ZERO_REG && wr_addr == '0)) begin
      w_bank_wr_en = 1'b1;
    end
  end

  regfile_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk        (CLK),
    .i_wr_en    (w_bank_wr_en),
    .i_wr_addr  (w_bank_wr_addr),
    .i_wr_data  (w_bank_wr_data),
    .i_rd_en    (rd_en),
    .i_rd_a_addr(rd_a_addr),
    .i_rd_b_addr(rd_b_addr),
    .o_rd_a_data(w_bank_q[0]),
    .o_rd_b_data(w_bank_q[1])
  );

  // Both ports share one captured copy of the write data for bypass hits
  always_ff @(posedge CLK) begin
    if (RST)        r_byp_data <= '0;
    else if (rd_en) r_byp_data <= wr_data;
  end

  assign w_rd_addr[0] = rd_a_addr;
  assign w_rd_addr[1] = rd_b_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      rd_sel_e          r_sel;
      rd_sel_e          w_sel_next;
      logic [WIDTH-1:0] w_out;

      always_comb begin
        w_sel_next = SEL_MEM;
        if (w_busy)
          w_sel_next = SEL_ZERO;
        else if (ZERO_REG && w_rd_addr[gi] == '0)
          w_sel_next = SEL_ZERO;
        else if (BYPASS && wr_en && wr_addr == w_rd_addr[gi])
          w_sel_next = SEL_BYP;
      end

      // Selector resets to zero so the output reads 0 straight after reset
      always_ff @(posedge CLK) begin
        if (RST)        r_sel <= SEL_ZERO;
        else if (rd_en) r_sel <= w_sel_next;
      end

      always_comb begin
        w_out = '0;
        case (r_sel)
          SEL_MEM:  w_out = w_bank_q[gi];
          SEL_BYP:  w_out = r_byp_data;
          default:  w_out = '0;
        endcase
      end

      assign w_rd_data[gi] = w_out;
    end
  endgenerate

  assign rd_a_data = w_rd_data[0];
  assign rd_b_data = w_rd_data[1];

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: two instances (zero+bypass, and neither) checked every cycle against a scoreboard model.
module tb_multiport_regfile;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wr_en, rd_en;
  logic [31:0] wr_data;
  logic [4:0]  wr_addr, rd_a_addr, rd_b_addr;
  logic [31:0] a0, b0, a1, b1;
  logic        busy0, busy1;

  always #5 CLK = ~CLK;

  multiport_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
    .CLK(CLK), .RST(RST), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_a_data(a0),
    .rd_b_addr(rd_b_addr), .rd_b_data(b0), .busy(busy0)
  );

  multiport_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .CLK(CLK), .RST(RST), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_a_data(a1),
    .rd_b_addr(rd_b_addr), .rd_b_data(b1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] a0, b0, a1, b1;
    logic        busy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic        mb   = 1'b1;
  int          mcnt = 0;
  logic [31:0] ea0 = '0, eb0 = '0, ea1 = '0, eb1 = '0;

  function automatic logic [31:0] rdv(input logic zr, input logic bp, input logic [4:0] ad,
                                      input logic [31:0] mv);
    if (zr && ad == 5'd0) return 32'd0;
    if (bp && wr_en && wr_addr == ad) return wr_data;
    return mv;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra, input logic [4:0] rb);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_a_addr = ra; rd_b_addr = rb;
  endtask

  // Predict this edge's outcome, push it, take the edge, then pop and compare both instances
  task automatic cycle();
    exp_t e;
    if (RST) begin
      ea0 = '0; eb0 = '0; ea1 = '0; eb1 = '0;
      mb = 1'b1; mcnt = 0;
    end else if (mb) begin
      if (rd_en) begin ea0 = '0; eb0 = '0; ea1 = '0; eb1 = '0; end
      m0[mcnt] = '0; m1[mcnt] = '0;
      if (mcnt == 31) begin mb = 1'b0; mcnt = 0; end
      else mcnt++;
    end else begin
      if (rd_en) begin
        ea0 = rdv(1'b1, 1'b1, rd_a_addr, m0[rd_a_addr]);
        eb0 = rdv(1'b1, 1'b1, rd_b_addr, m0[rd_b_addr]);
        ea1 = rdv(1'b0, 1'b0, rd_a_addr, m1[rd_a_addr]);
        eb1 = rdv(1'b0, 1'b0, rd_b_addr, m1[rd_b_addr]);
      end
      if (wr_en) begin
        if (wr_addr != 5'd0) m0[wr_addr] = wr_data;
        m1[wr_addr] = wr_data;
      end
    end
    e = '{a0: ea0, b0: eb0, a1: ea1, b1: eb1, busy: mb};
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("busy0", {31'd0, busy0}, {31'd0, e.busy});
    chk("busy1", {31'd0, busy1}, {31'd0, e.busy});
    chk("rd_a0", a0, e.a0);
    chk("rd_b0", b0, e.b0);
    chk("rd_a1", a1, e.a1);
    chk("rd_b1", b1, e.b1);
    if (rd_en && !RST)
      $display("t=%0t rd a[%0d] %h/%h b[%0d] %h/%h busy=%0b",
               $time, rd_a_addr, a0, a1, rd_b_addr, b0, b1, busy0);
  endtask

  // Edges until busy falls, bounded so a stuck clear cannot hang the run
  task automatic count_clear(input string tag);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n++;
      if (!busy0) break;
    end
    chk(tag, 32'(n), 32'd32);
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

    // 1. reset, clear sweep with a write attempt during busy
    cycle();
    cycle();
    chk("rst_busy", {31'd0, busy0}, 32'd1);
    chk("rst_a", a0, 32'd0);
    RST = 1'b0;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd6);
    count_clear("clear_len");
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i));
      cycle();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);
    cycle();
    chk("busy_wr_dropped", a0, 32'd0);

    // 2. basic write then read on both ports
    drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd0);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);
    cycle();
    chk("basic_a", a0, 32'h12345678);
    chk("basic_b", b0, 32'h12345678);

    // 3. hardwired zero register vs plain instance
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    cycle();
    chk("zero_on", a0, 32'd0);
    chk("zero_off", a1, 32'hFFFFFFFF);

    // 4. same-cycle read-after-write
    drive(1'b1, 5'd3, 32'hAAAA0000, 1'b0, 5'd0, 5'd0);
    cycle();
    drive(1'b1, 5'd4, 32'h00004444, 1'b0, 5'd0, 5'd0);
    cycle();
    drive(1'b1, 5'd3, 32'h00005555, 1'b1, 5'd3, 5'd4);
    cycle();
    chk("byp_a_on", a0, 32'h00005555);
    chk("byp_b_on", b0, 32'h00004444);
    chk("byp_a_off", a1, 32'hAAAA0000);

    // 5. stall holds outputs while address and contents change
    drive(1'b1, 5'd1, 32'h00000011, 1'b0, 5'd0, 5'd0);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 32'h99 + 32'(i), 1'b0, 5'(i + 2), 5'(i + 9));
      cycle();
      chk("stall_hold", a0, 32'h00000011);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd1);
    cycle();
    chk("stall_release", a0, 32'h0000009B);

    // 6a. reset at clear cycle 10 restarts the full sweep
    RST = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd3);
    cycle();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    RST = 1'b1;
    cycle();
    chk("midclr_busy", {31'd0, busy0}, 32'd1);
    RST = 1'b0;
    count_clear("midclr_len");

    // 6b. reset in READY re-zeroes written entries
    for (int i = 8; i < 12; i++) begin
      drive(1'b1, 5'(i), 32'h1234 + 32'(i), 1'b0, 5'd0, 5'd0);
      cycle();
    end
    RST = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    cycle();
    RST = 1'b0;
    count_clear("ready_rst_len");
    for (int i = 8; i < 12; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i));
      cycle();
      chk("rezero_a", a0, 32'd0);
      chk("rezero_b1", b1, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
Name: multiport_regfile

Overview:
- Parametrised successor to the CPU's single-write/single-read register memory.
- Provides one write port and two independent registered read ports (rs1/rs2), with optional hardwired-zero register 0 and optional write-to-read bypass.
- Performs a self-clear of all entries after reset, driven by a small state machine, and reports a busy flag while clearing.
- Sits in the CPU register stage between decode (read addresses) and writeback (write port).

Parameters:
- WIDTH, 32, data width of each entry in bits.
- DEPTH, 32, number of entries; must be a power of two and at least 2. ADDR_W = $clog2(DEPTH).
- ZERO_REG, 1, when 1 address 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, when 1 a read and a write to the same address in the same cycle return the new write data.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- wr_data  input  WIDTH  write data.
- wr_addr  input  ADDR_W  write address.
- wr_en  input  1  write strobe.
- rd_en  input  1  read enable for both ports; when low both outputs hold (pipeline stall).
- rd_a_addr  input  ADDR_W  read port A address.
- rd_a_data  output  WIDTH  read port A data, registered.
- rd_b_addr  input  ADDR_W  read port B address.
- rd_b_data  output  WIDTH  read port B data, registered.
- busy  output  1  high while the clear sequence runs; the block accepts no writes and returns 0 on reads while high.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset (RST sampled high at an edge):
  - state <= CLEAR, clr_cnt <= 0, rd_a_data <= 0, rd_b_data <= 0.
  - busy = (state == CLEAR), so busy reads 1 after the reset edge.
- CLEAR state (RST low):
  - Each edge writes 0 to mem[clr_cnt] and increments clr_cnt.
  - When clr_cnt == DEPTH-1, the edge writes the last entry, sets state <= READY and sets clr_cnt <= 0.
  - busy is high for exactly DEPTH edges after the first edge with RST low.
  - wr_en is ignored.
  - If rd_en is high, rd_*_data <= 0; if rd_en is low, the outputs hold.
- READY state:
  - Write: when wr_en is high and not (ZERO_REG and wr_addr == 0), mem[wr_addr] <= wr_data at the edge.
  - Read: when rd_en is high, rd_x_data <= value for rd_x_addr, with latency 1 edge. When rd_en is low, rd_x_data holds its previous value.
  - Read value priority, highest first:
    1. ZERO_REG and addr == 0 -> 0.
    2. BYPASS and wr_en and wr_addr == addr -> wr_data.
    3. Otherwise -> mem[addr], the pre-edge contents.
  - With BYPASS = 0, a same-cycle read-after-write returns the old contents.
  - Both read ports may address the same entry; each independently obeys the priority rules.
- RST asserted mid-clear: the clear sequence restarts from clr_cnt = 0, with full DEPTH cycles again.
- RST asserted in READY: the block returns to CLEAR and memory is re-zeroed. No state persists across reset.
- The state register has no other transitions. An illegal state encoding goes to CLEAR.
- Memory is a plain array with no read-port reset, so it is inferable as distributed RAM or a register array. The clear is done through the write port, not by a reset of the array.

Decomposition:
- Package regfile_pkg:
  - State enum {CLEAR, READY}, 1 bit.
  - Function addr_w(depth) returning $clog2(depth).
  - Default constants REG_WIDTH = 32 and REG_DEPTH = 32, shared with the decode and writeback stages.
- Sub-module regfile_bank:
  - Contains the storage array, one synchronous write port and two registered read ports with hold-enable.
  - Has no zero, bypass or clear logic.
  - The top level muxes the write port between the clear counter and wr_*, and applies the zero and bypass logic on the read addresses and data.

Test Plan:
1. Reset then clear: RST high 2 cycles, then low -> busy is high for exactly 32 edges then 0; reads of addresses 0..31 then return 0. With wr_en = 1, wr_addr = 5, wr_data = 0xDEADBEEF during busy, a later read of address 5 returns 0.
2. Basic write/read: write 0x12345678 to address 7, then next cycle rd_a_addr = 7 and rd_b_addr = 7 -> both outputs show 0x12345678 one edge later.
3. Zero register: write 0xFFFFFFFF to address 0, then read address 0 on A -> 0. With ZERO_REG = 0 in a second instance, the same sequence -> 0xFFFFFFFF.
4. Bypass: address 3 holds 0xAAAA0000; in one cycle wr_en = 1, wr_addr = 3, wr_data = 0x5555, rd_a_addr = 3, rd_b_addr = 4 -> A = 0x5555, B = old mem[4]. With BYPASS = 0 -> A = 0xAAAA0000.
5. Stall: rd_a_data = 0x11 with rd_en low for 3 cycles while rd_a_addr changes and address 1 is written -> output stays 0x11. When rd_en goes high -> output updates next edge.
6. Reset mid-clear: assert RST at clear cycle 10 for 1 cycle -> busy remains high, and exactly 32 further edges elapse before busy falls. Reset in READY after writes -> all entries read 0 after the clear.
